btn_event_ctrl: RTL and testbench

- Debounces NUM_BTN raw button inputs using one shared 1 ms tick prescaler instead of one 33-bit counter per button.
- Turns debounced edges into press/release events.
- Serialises events onto one valid/ready stream through a round-robin arbiter.
- Sits between the board pushbuttons and the UI/command FSMs that consume button events.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_event_ctrl_if.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/btn_event_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and elaboration-time helpers for the button event controller.
package btn_pkg;

   // Id field wide enough for the largest supported button count (16).
   localparam int ID_W = 4;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            press;
   } ev_t;

   function automatic int ms_div(input int clkfreq);
      return clkfreq / 1000;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Valid/ready button event stream; the controller drives it as master.
interface btn_event_ctrl_if #(
   parameter int NUM_BTN = 5
);
   import btn_pkg::*;

   localparam int EV_ID_W = clog2_min1(NUM_BTN);

   logic               ev_valid;
   logic               ev_ready;
   logic [EV_ID_W-1:0] ev_id;
   logic               ev_press;

   modport master (output ev_valid, output ev_id, output ev_press, input ev_ready);
   modport slave  (input ev_valid, input ev_id, input ev_press, output ev_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
   import btn_pkg::*;
#(
   parameter int N = 5,
   localparam int PW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          gnt_valid,
   output logic [PW-1:0] gnt_idx
);

   int j;

   // NOTE: every output gets a default first so no path through the loop infers a latch.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      // Walk from the farthest offset down so the nearest request is written last and wins.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            gnt_valid = 1'b1;
            gnt_idx   = PW'(j);
         end
      end
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounces NUM_BTN buttons off a shared 1 ms tick and streams press/release events.
// Define AUTOREPEAT_EN to post repeat press events while a button stays held.
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter int NUM_BTN          = 5,
   parameter int CLKFREQ          = 100_000_000,
   parameter int DEBOUNCE_TIME_MS = 5,
   parameter int REPEAT_DELAY_MS  = 500,
   parameter int REPEAT_PERIOD_MS = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_state,
   output logic               overrun,
   btn_event_ctrl_if.master   ev
);

   localparam int DIV     = ms_div(CLKFREQ);
   localparam int PRE_W   = clog2_min1(DIV);
   localparam int CNT_W   = $clog2(DEBOUNCE_TIME_MS);
   localparam int EV_ID_W = clog2_min1(NUM_BTN);

   logic [NUM_BTN-1:0] sync1_q, s_q;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic               tick;
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] state_q, state_d;
   logic [NUM_BTN-1:0] edge_ev, rep_ev, new_ev, new_type;
   logic [NUM_BTN-1:0] pend_q, pend_d, ptype_q, ptype_d;
   logic [EV_ID_W-1:0] rr_q, rr_d, gnt_idx, ev_id_q, ev_id_d;
   logic               gnt_valid, loadable;
   logic               ev_valid_q, ev_valid_d, ev_press_q, ev_press_d;
   logic               overrun_q, overrun_d;

   always_comb begin
      tick  = (pre_q == PRE_W'(DIV - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   // Counter only advances on ticks while the synchronised level disagrees.
   always_comb begin
      state_d = state_q;
      edge_ev = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s_q[i] == state_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_TIME_MS - 1)) begin
               state_d[i] = ~state_q[i];
               cnt_d[i]   = '0;
               edge_ev[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS
                                                                  : REPEAT_PERIOD_MS;
   localparam int HOLD_W   = clog2_min1(HOLD_MAX + 1);

   logic [HOLD_W-1:0]  hold_q [NUM_BTN];
   logic [HOLD_W-1:0]  hold_d [NUM_BTN];
   logic [NUM_BTN-1:0] first_q, first_d;
   logic [HOLD_W:0]    hold_inc, hold_tgt;

   // first_q selects the initial delay; after each repeat the counter restarts on the period.
   always_comb begin
      rep_ev   = '0;
      first_d  = first_q;
      hold_inc = '0;
      hold_tgt = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         hold_d[i] = hold_q[i];
         hold_inc  = {1'b0, hold_q[i]} + (HOLD_W + 1)'(1);
         hold_tgt  = first_q[i] ? (HOLD_W + 1)'(REPEAT_DELAY_MS) : (HOLD_W + 1)'(REPEAT_PERIOD_MS);
         if (!state_q[i] || edge_ev[i]) begin
            hold_d[i]  = '0;
            first_d[i] = 1'b1;
         end else if (tick) begin
            if (hold_inc == hold_tgt) begin
               rep_ev[i]  = 1'b1;
               hold_d[i]  = '0;
               first_d[i] = 1'b0;
            end else if (hold_q[i] != '1) begin
               hold_d[i] = hold_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= '1;
         for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
      end else begin
         first_q <= first_d;
         for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
      end
   end
`else
   assign rep_ev = '0;
`endif

   // A release edge takes precedence over a repeat landing on the same tick.
   assign new_ev   = edge_ev | rep_ev;
   assign new_type = state_d | ~edge_ev;
   assign loadable = !ev_valid_q || ev.ev_ready;

   rr_arbiter #(.N(NUM_BTN)) u_arb (
      .req       (pend_q),
      .ptr       (rr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Grant clears first, then new events set: a same-cycle set beats the clear.
   always_comb begin
      pend_d     = pend_q;
      ptype_d    = ptype_q;
      rr_d       = rr_q;
      ev_valid_d = ev_valid_q;
      ev_id_d    = ev_id_q;
      ev_press_d = ev_press_q;
      overrun_d  = overrun_q;
      if (loadable) begin
         if (gnt_valid) begin
            ev_valid_d      = 1'b1;
            ev_id_d         = gnt_idx;
            ev_press_d      = ptype_q[gnt_idx];
            pend_d[gnt_idx] = 1'b0;
            rr_d            = (gnt_idx == EV_ID_W'(NUM_BTN - 1)) ? '0 : gnt_idx + 1'b1;
         end else begin
            ev_valid_d = 1'b0;
         end
      end
      for (int i = 0; i < NUM_BTN; i++) begin
         if (new_ev[i]) begin
            if (pend_d[i]) overrun_d = 1'b1;
            pend_d[i]  = 1'b1;
            ptype_d[i] = new_type[i];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         s_q        <= '0;
         pre_q      <= '0;
         state_q    <= '0;
         pend_q     <= '0;
         ptype_q    <= '0;
         rr_q       <= '0;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
         ev_press_q <= 1'b0;
         overrun_q  <= 1'b0;
         // NOTE: the per-button counters are plain flops, not a RAM, so each entry is reset.
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q    <= btn_in;
         s_q        <= sync1_q;
         pre_q      <= pre_d;
         state_q    <= state_d;
         pend_q     <= pend_d;
         ptype_q    <= ptype_d;
         rr_q       <= rr_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q    <= ev_id_d;
         ev_press_q <= ev_press_d;
         overrun_q  <= overrun_d;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign btn_state   = state_q;
   assign overrun     = overrun_q;
   assign ev.ev_valid = ev_valid_q;
   assign ev.ev_id    = ev_id_q;
   assign ev.ev_press = ev_press_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: a behavioural model predicts events, a monitor checks them.
module tb_btn_event_ctrl;
   import btn_pkg::*;

   localparam int NB   = 5;
   localparam int CLKF = 10_000;
   localparam int DB   = 5;
   localparam int RD   = 500;
   localparam int RP   = 100;
   localparam int DIV  = CLKF / 1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_state;
   logic          overrun;

   btn_event_ctrl_if #(.NUM_BTN(NB)) ev_if ();

   btn_event_ctrl #(
      .NUM_BTN          (NB),
      .CLKFREQ          (CLKF),
      .DEBOUNCE_TIME_MS (DB),
      .REPEAT_DELAY_MS  (RD),
      .REPEAT_PERIOD_MS (RP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .btn_state (btn_state),
      .overrun   (overrun),
      .ev        (ev_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_events = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: debounce as "DB consecutive ms ticks of disagreement", one slot per button.
   bit [NB-1:0] m_sync1, m_s, m_state, m_pend, m_ptype;
   bit [NB-1:0] m_sold, m_old_state, m_new_ev, m_new_type;
   int          m_diff [NB];
   int          m_hold [NB];
   int          m_pre, m_rr, m_g;
   bit          m_valid, m_overrun, m_tick;
   ev_t         m_ev;
   ev_t         exp_q [$];

   always @(posedge clk) begin : model
      if (!rst_n) begin
         m_sync1 = '0; m_s = '0; m_state = '0; m_pend = '0; m_ptype = '0;
         m_pre = 0; m_rr = 0; m_valid = 1'b0; m_overrun = 1'b0;
         for (int i = 0; i < NB; i++) begin
            m_diff[i] = 0;
            m_hold[i] = 0;
         end
         exp_q.delete();
      end else begin
         m_sold      = m_s;
         m_old_state = m_state;
         m_s         = m_sync1;
         m_sync1     = btn_in;
         m_tick      = (m_pre == DIV - 1);
         m_pre       = m_tick ? 0 : m_pre + 1;
         m_new_ev    = '0;
         m_new_type  = '0;
         for (int i = 0; i < NB; i++) begin
            if (m_sold[i] == m_state[i]) begin
               m_diff[i] = 0;
            end else if (m_tick) begin
               m_diff[i]++;
               if (m_diff[i] == DB) begin
                  m_diff[i]     = 0;
                  m_state[i]    = m_sold[i];
                  m_new_ev[i]   = 1'b1;
                  m_new_type[i] = m_sold[i];
               end
            end
`ifdef AUTOREPEAT_EN
            if (!m_old_state[i] || m_new_ev[i]) begin
               m_hold[i] = 0;
            end else if (m_tick) begin
               m_hold[i]++;
               if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0)) begin
                  m_new_ev[i]   = 1'b1;
                  m_new_type[i] = 1'b1;
               end
            end
`endif
         end
         if (!m_valid || ev_if.ev_ready) begin
            m_g = -1;
            for (int k = 0; k < NB; k++)
               if (m_g < 0 && m_pend[(m_rr + k) % NB]) m_g = (m_rr + k) % NB;
            if (m_g >= 0) begin
               m_ev.id    = ID_W'(m_g);
               m_ev.press = m_ptype[m_g];
               exp_q.push_back(m_ev);
               m_pend[m_g] = 1'b0;
               m_valid     = 1'b1;
               m_rr        = (m_g + 1) % NB;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int i = 0; i < NB; i++) begin
            if (m_new_ev[i]) begin
               if (m_pend[i]) m_overrun = 1'b1;
               m_pend[i]  = 1'b1;
               m_ptype[i] = m_new_type[i];
            end
         end
      end
   end

   // Monitor: mid-cycle, compare outputs against the model and pop on each handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("btn_state", 32'(btn_state), 32'(m_state));
         check("overrun", 32'(overrun), 32'(m_overrun));
         check("ev_valid", 32'(ev_if.ev_valid), 32'(exp_q.size() != 0));
         if (ev_if.ev_valid && exp_q.size() != 0) begin
            check("ev_id", 32'(ev_if.ev_id), 32'(exp_q[0].id));
            check("ev_press", 32'(ev_if.ev_press), 32'(exp_q[0].press));
            if (ev_if.ev_ready) begin
               void'(exp_q.pop_front());
               n_events++;
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ms(input int n);
      wait_cyc(n * DIV);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int base;
      int w;
      ev_if.ev_ready = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_btn_state", 32'(btn_state), 32'd0);
      check("rst_ev_valid", 32'(ev_if.ev_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      wait_cyc(1);

      // Clean press and release on button 2.
      base = n_events;
      btn_in[2] = 1'b1;
      wait_ms(8);
      btn_in[2] = 1'b0;
      wait_ms(8);
      check("clean_events", 32'(n_events - base), 32'd2);

      // Bounce button 0 for 40 cycles, then hold.
      base = n_events;
      for (int k = 0; k < 40; k++) begin
         btn_in[0] = ((k / 3) % 2 == 0);
         wait_cyc(1);
      end
      check("bounce_no_event", 32'(n_events - base), 32'd0);
      btn_in[0] = 1'b1;
      wait_ms(8);
      check("bounce_one_press", 32'(n_events - base), 32'd1);
      btn_in[0] = 1'b0;
      wait_ms(8);

      // All buttons at once: five back-to-back presses, then five releases.
      base = n_events;
      btn_in = '1;
      wait_ms(8);
      check("all_press_events", 32'(n_events - base), 32'd5);
      btn_in = '0;
      wait_ms(8);
      check("all_release_events", 32'(n_events - base), 32'd10);

      // Stalled consumer: button 1 toggles twice; pending slot overwritten.
      base = n_events;
      ev_if.ev_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         btn_in[1] = 1'b1;
         wait_ms(8);
         btn_in[1] = 1'b0;
         wait_ms(8);
      end
      check("stall_overrun", 32'(overrun), 32'd1);
      check("stall_no_transfer", 32'(n_events - base), 32'd0);
      ev_if.ev_ready = 1'b1;
      wait_ms(2);
      check("stall_events", 32'(n_events - base), 32'd2);

      // Reset mid-handshake with button 0 held.
      ev_if.ev_ready = 1'b0;
      btn_in[0] = 1'b1;
      w = 0;
      while (!ev_if.ev_valid && w < 400) begin
         wait_cyc(1);
         w++;
      end
      check("reset_valid_seen", 32'(w < 400), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(ev_if.ev_valid), 32'd0);
      check("async_rst_state", 32'(btn_state), 32'd0);
      check("async_rst_overrun", 32'(overrun), 32'd0);
      wait_cyc(3);
      rst_n = 1'b1;
      ev_if.ev_ready = 1'b1;
      base = n_events;
      wait_ms(8);
      check("post_rst_press", 32'(n_events - base), 32'd1);
      btn_in[0] = 1'b0;
      wait_ms(8);

      // Long hold on button 3.
      base = n_events;
      btn_in[3] = 1'b1;
      wait_ms(800);
      btn_in[3] = 1'b0;
      wait_ms(8);
`ifdef AUTOREPEAT_EN
      check("hold_events", 32'(n_events - base), 32'd5);
`else
      check("hold_events", 32'(n_events - base), 32'd2);
`endif

      // Randomised toggling with an intermittently stalled consumer.
      for (int it = 0; it < 400; it++) begin
         btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
         ev_if.ev_ready = ($urandom_range(0, 3) != 0);
         wait_cyc($urandom_range(1, 80));
      end
      ev_if.ev_ready = 1'b1;
      btn_in = '0;
      wait_ms(12);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_valid", 32'(ev_if.ev_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
